sprite_motion_controller: RTL and testbench
===========================================

// Module: sprite_motion_controller
// PURPOSE
//  Sequences the sprite printer's position inputs (posx/posy) once per video frame.
//  - Pixel counters feed it from the VGA sync generator.
//  - posx/posy change only in vertical blank, so a sprite is never torn mid-frame.
//  - Two modes: manual (four direction buttons, clamped at screen edges) or
//    auto (bouncing motion).
// PARAMETERS
//  H_ACTIVE     640  visible pixels per line
//  V_ACTIVE     480  visible lines per frame
//  SPRITE_SIZE   64  sprite width/height in pixels (square)
//  STEP           4  pixels moved per update, each axis (1..SPRITE_SIZE)
//  FRAME_DIV      2  frames per position update (>=1)
// PORTS
//  clk         in   1   system clock (may exceed pixel rate; counters can hold for >1 clk)
//  rst         in   1   asynchronous reset, active-low
//  pixelx      in  10   current pixel x from the VGA counter
//  pixely      in  10   current pixel y from the VGA counter
//  btn_up      in   1   level, debounced and synchronous to clk
//  btn_down    in   1   level, debounced and synchronous to clk
//  btn_left    in   1   level, debounced and synchronous to clk
//  btn_right   in   1   level, debounced and synchronous to clk
//  auto_en     in   1   1 = bounce mode, 0 = manual mode
//  posx        out 10   sprite top-left x, to the sprite printer
//  posy        out 10   sprite top-left y, to the sprite printer
//  frame_tick  out  1   1-clk pulse at each detected frame end
//  busy        out  1   1 while FSM is outside IDLE
// BEHAVIOUR
//  Limits: XMAX = H_ACTIVE-SPRITE_SIZE (576), YMAX = V_ACTIVE-SPRITE_SIZE (416).
//  Reset values (async, rst=0):
//   - posx = XMAX/2 = 288, posy = YMAX/2 = 208
//   - dirx = diry = +1; frame counter = 0; FSM = IDLE
//   - frame_tick = 0, busy = 0
//  Frame detect:
//   - fe = (pixelx==0 && pixely==V_ACTIVE); fe is registered.
//   - frame_tick = fe & ~fe_q: exactly one pulse per frame however long fe holds.
//  Frame divider:
//   - On frame_tick: fcnt increments; at FRAME_DIV-1 it wraps to 0 and FSM leaves IDLE.
//   - Ticks arriving while busy are counted but never start a second pass.
//  FSM, one state per clk:
//   - IDLE -> SAMPLE on divider wrap.
//   - SAMPLE: latch btn_* and auto_en into holding regs. Later input changes
//     do not affect this update.
//   - CALC: compute nx, ny in 11-bit signed arithmetic (no 10-bit wrap):
//     - Manual: dx = +STEP if right only, -STEP if left only, 0 if neither or both.
//       dy likewise for down/up (up = -). Result clamped to [0,XMAX] / [0,YMAX].
//     - Auto: nx = posx + dirx*STEP. If nx>XMAX: nx=XMAX, dirx=-1.
//       If nx<0: nx=0, dirx=+1. Y axis identical with YMAX/diry.
//       Landing exactly on a limit does not flip dir; the flip happens next update.
//   - COMMIT: posx<=nx, posy<=ny -> IDLE.
//  Latency: posx/posy change 3 clks after the frame_tick that wraps the divider.
//   The update lands inside vblank (lines 480..524) with margin.
//  Mode switch: dirx/diry persist across manual periods. Switching to auto
//   resumes with the last bounce direction.
//  Reset mid-operation: state and outputs return immediately to reset values.
//   No partial commit.
//  Positions are always within [0,XMAX] x [0,YMAX]; no illegal value ever appears.
// TESTING
//  1. Reset, FRAME_DIV=1, no buttons, auto_en=0, run 3 frames
//     -> posx=288, posy=208 throughout; 3 frame_tick pulses.
//  2. Hold fe for 4 clks (clk = 2x pixel clock)
//     -> exactly one frame_tick; busy high 3 clks.
//  3. Manual, btn_right=1, posx=574, STEP=4
//     -> next update posx=576, then stays 576.
//     left+right together -> posx unchanged.
//  4. Auto, posx=574, dirx=+1 -> next posx=576, dirx=-1; following update posx=572.
//     posy=2, diry=-1 -> posy=0, then posy=4.
//  5. FRAME_DIV=2, btn_down held
//     -> posy steps 208,212,216 every 2nd frame_tick only.
//  6. Assert rst in CALC with btn_left held
//     -> posx=288, posy=208, busy=0 immediately; no commit after rst release.

Source files
------------

// File: rtl/sprite_motion_controller.sv
// Per-frame sprite position sequencer: detects frame end from the VGA pixel
// counters and moves posx/posy once every FRAME_DIV frames, during vertical blank.
module sprite_motion_controller #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SPRITE_SIZE = 64,
  parameter int STEP        = 4,
  parameter int FRAME_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pixelx,
  input  logic [9:0] pixely,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       auto_en,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic       frame_tick,
  output logic       busy
);

  localparam int XMAX = H_ACTIVE - SPRITE_SIZE;
  localparam int YMAX = V_ACTIVE - SPRITE_SIZE;
  localparam int FW   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [FW-1:0]     FLAST = FW'(FRAME_DIV - 1);
  localparam logic signed [10:0] SSTEP = 11'(STEP);
  localparam logic signed [10:0] SXMAX = 11'(XMAX);
  localparam logic signed [10:0] SYMAX = 11'(YMAX);
  localparam logic [9:0]         XRST  = 10'(XMAX / 2);
  localparam logic [9:0]         YRST  = 10'(YMAX / 2);
  localparam logic [9:0]         VFE   = 10'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, SAMPLE, CALC, COMMIT} state_t;

  state_t        state;
  logic          fe_r, fe_q;
  logic [FW-1:0] fcnt;
  logic          up_l, down_l, left_l, right_l, auto_l;
  logic          dirx_neg, diry_neg, ndirx_neg, ndiry_neg;
  logic [9:0]    nx_r, ny_r;
  logic [10:0]   xnext, ynext;

  // One axis update in 11-bit signed arithmetic; returns {new_dir_neg, new_pos}.
  function automatic logic [10:0] axis_next(input logic [9:0] pos, input logic neg,
                                            input logic inc, input logic dec,
                                            input logic auto_m, input logic signed [10:0] lim);
    logic signed [10:0] p;
    logic signed [10:0] n;
    logic               nn;
    p  = signed'({1'b0, pos});
    nn = neg;
    n  = p;
    if (auto_m) begin
      n = neg ? p - SSTEP : p + SSTEP;
      if (n > lim) begin
        n  = lim;
        nn = 1'b1;
      end else if (n < 11'sd0) begin
        n  = '0;
        nn = 1'b0;
      end
    end else begin
      if (inc && !dec)      n = p + SSTEP;
      else if (dec && !inc) n = p - SSTEP;
      if (n > lim)             n = lim;
      else if (n < 11'sd0)     n = '0;
    end
    return {nn, n[9:0]};
  endfunction

  assign xnext      = axis_next(posx, dirx_neg, right_l, left_l, auto_l, SXMAX);
  assign ynext      = axis_next(posy, diry_neg, down_l, up_l, auto_l, SYMAX);
  assign frame_tick = fe_r & ~fe_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fe_r      <= 1'b0;
      fe_q      <= 1'b0;
      fcnt      <= '0;
      up_l      <= 1'b0;
      down_l    <= 1'b0;
      left_l    <= 1'b0;
      right_l   <= 1'b0;
      auto_l    <= 1'b0;
      dirx_neg  <= 1'b0;
      diry_neg  <= 1'b0;
      ndirx_neg <= 1'b0;
      ndiry_neg <= 1'b0;
      nx_r      <= XRST;
      ny_r      <= YRST;
      posx      <= XRST;
      posy      <= YRST;
      busy      <= 1'b0;
    end else begin
      fe_r <= (pixelx == '0) && (pixely == VFE);
      fe_q <= fe_r;
      if (frame_tick) fcnt <= (fcnt == FLAST) ? '0 : fcnt + 1'b1;
      case (state)
        IDLE: begin
          // Wraps that land while busy are dropped so a pass never restarts.
          if (frame_tick && fcnt == FLAST) begin
            state <= SAMPLE;
            busy  <= 1'b1;
          end
        end
        SAMPLE: begin
          up_l    <= btn_up;
          down_l  <= btn_down;
          left_l  <= btn_left;
          right_l <= btn_right;
          auto_l  <= auto_en;
          state   <= CALC;
        end
        CALC: begin
          {ndirx_neg, nx_r} <= xnext;
          {ndiry_neg, ny_r} <= ynext;
          state             <= COMMIT;
        end
        COMMIT: begin
          posx     <= nx_r;
          posy     <= ny_r;
          dirx_neg <= ndirx_neg;
          diry_neg <= ndiry_neg;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_controller.sv
// Randomized bench for sprite_motion_controller against a per-frame position model.
module tb_sprite_motion_controller;

  localparam int XMAX = 576;
  localparam int YMAX = 416;
  localparam int STEP = 4;
  localparam int DIV  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pixelx, pixely;
  logic       btn_up, btn_down, btn_left, btn_right, auto_en;
  logic [9:0] posx, posy;
  logic       frame_tick, busy;

  int errors = 0;
  int checks = 0;
  int ticks  = 0;
  int busyc  = 0;

  int mx, my, mdx, mdy, mfcnt;

  sprite_motion_controller #(
    .H_ACTIVE(640), .V_ACTIVE(480), .SPRITE_SIZE(64), .STEP(STEP), .FRAME_DIV(DIV)
  ) dut (
    .clk(clk), .rst(rst), .pixelx(pixelx), .pixely(pixely),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .auto_en(auto_en), .posx(posx), .posy(posy), .frame_tick(frame_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      if (frame_tick) ticks = ticks + 1;
      if (busy)       busyc = busyc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    mx = XMAX / 2; my = YMAX / 2; mdx = 1; mdy = 1; mfcnt = 0;
  endfunction

  function automatic void step_axis(inout int p, inout int d, input bit inc, input bit dec,
                                    input bit a, input int lim);
    if (a) begin
      p = p + d * STEP;
      if (p > lim)    begin p = lim; d = -1; end
      else if (p < 0) begin p = 0;   d = 1;  end
    end else begin
      if (inc && !dec)      p = p + STEP;
      else if (dec && !inc) p = p - STEP;
      if (p > lim) p = lim;
      if (p < 0)   p = 0;
    end
  endfunction

  task automatic set_in(input bit r, input bit l, input bit d, input bit u, input bit a);
    btn_right = r; btn_left = l; btn_down = d; btn_up = u; auto_en = a;
  endtask

  task automatic pixels_off();
    pixely = 10'($urandom_range(0, 524));
    pixelx = 10'($urandom_range(0, 799));
    if (pixelx == 10'd0 && pixely == 10'd480) pixelx = 10'd1;
  endtask

  // One frame end: fe held for 'hold' clks, then a gap while the update completes.
  task automatic frame(input int hold, input bit perturb, input bit do_rst);
    int t0, b0, ox, oy, gap;
    bit upd, r, l, d, u, a;
    logic [4:0] junk;
    t0 = ticks; b0 = busyc; ox = mx; oy = my;
    r = btn_right; l = btn_left; d = btn_down; u = btn_up; a = auto_en;
    upd   = (mfcnt == DIV - 1);
    mfcnt = (mfcnt + 1) % DIV;
    pixelx = 10'd0; pixely = 10'd480;
    gap = 8 + $urandom_range(0, 4);
    for (int i = 1; i <= gap; i++) begin
      @(posedge clk); #1;
      if (i == hold) pixels_off();
      if (i == 3) begin
        if (do_rst) begin
          rst = 1'b0; #1;
          check("rst_posx", posx, 288);
          check("rst_posy", posy, 208);
          check("rst_busy", busy, 0);
        end else if (perturb) begin
          junk = 5'($urandom);
          set_in(junk[0], junk[1], junk[2], junk[3], junk[4]);
        end
      end
      if (i == 4 && !do_rst) begin
        check("hold_posx", posx, ox);
        check("hold_posy", posy, oy);
      end
      if (i == 5 && do_rst) rst = 1'b1;
    end
    if (do_rst) model_reset();
    else if (upd) begin
      step_axis(mx, mdx, r, l, a, XMAX);
      step_axis(my, mdy, d, u, a, YMAX);
    end
    check("posx", posx, mx);
    check("posy", posy, my);
    check("busy_idle", busy, 0);
    if (!do_rst) begin
      check("ticks", ticks - t0, 1);
      check("busy_clks", busyc - b0, upd ? 3 : 0);
    end
  endtask

  task automatic run(input int n, input bit r, input bit l, input bit d, input bit u,
                     input bit a, input bit perturb);
    for (int k = 0; k < n; k++) begin
      set_in(r, l, d, u, a);
      frame($urandom_range(1, 4), perturb, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0;
    pixelx = 10'd5; pixely = 10'd100;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_posx", posx, 288);
    check("reset_posy", posy, 208);
    check("reset_busy", busy, 0);
    check("reset_tick", frame_tick, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run(6, 0, 0, 0, 0, 0, 1);
    run(200, 1, 0, 0, 0, 0, 1);
    run(6, 1, 1, 0, 0, 0, 1);
    run(40, 0, 0, 1, 0, 0, 1);
    run(500, 0, 0, 0, 0, 1, 1);

    while (mfcnt != DIV - 1) run(1, 0, 0, 0, 0, 0, 0);
    set_in(0, 1, 0, 0, 0);
    frame(1, 1'b0, 1'b1);
    run(4, 0, 0, 0, 0, 0, 0);

    for (int b = 0; b < 12; b++) begin
      logic [4:0] v;
      v = 5'($urandom);
      run($urandom_range(10, 60), v[0], v[1], v[2], v[3], v[4], 1);
    end
    run(250, 0, 1, 0, 1, 0, 1);
    run(20, 0, 0, 0, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
